// File: rtl/ad80305_pkg.sv
// ad80305_pkg: shared types and constants for the AD80305 RX frame-alignment path.
// Rev 1.0
`default_nettype none

package ad80305_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } rx_state_e;

    localparam int DEFAULT_DW = 12;

    // FIFO word layout: Q occupies the upper DW bits, I the lower DW bits.
    localparam bit PACK_Q_HIGH = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ad80305_sat_cnt.sv
// ad80305_sat_cnt: saturating up-counter with synchronous clear (clear beats increment).
// Rev 1.0
`default_nettype none

module ad80305_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ad80305_rx_frame_align.sv
// ad80305_rx_frame_align: rx_frame lock FSM, I/Q de-interleave and FIFO write control.
// Rev 1.0
`default_nettype none

module ad80305_rx_frame_align
    import ad80305_pkg::*;
#(
    parameter int DW         = DEFAULT_DW,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic              i_rx_clk,
    input  logic              i_fpga_rst_125p,
    input  logic [DW:0]       i_dataout_h,
    input  logic [DW:0]       i_dataout_l,
    input  logic              i_enable,
    input  logic              i_wrfull,
    input  logic              i_clr_cnt,
    output logic              o_wr_en,
    output logic [2*DW-1:0]   o_wr_data,
    output logic              o_locked,
    output logic              o_phase,
    output logic [CNT_W-1:0]  o_frame_err_cnt,
    output logic [CNT_W-1:0]  o_ovf_cnt
);

    localparam logic [7:0] LOCK_V   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_V = 8'(UNLOCK_CNT);

    logic [DW:0]     h_q;
    logic [DW:0]     l_q;
    rx_state_e       state;
    rx_state_e       state_d;
    logic            ref_phase;
    logic            ref_phase_d;
    logic [7:0]      good_cnt;
    logic [7:0]      good_cnt_d;
    logic [7:0]      bad_cnt;
    logic [7:0]      bad_cnt_d;
    logic            good_pat;
    logic            ph;
    logic            is_good;
    logic            wr_fire;
    logic            ovf_inc;
    logic            err_inc;
    logic [DW-1:0]   i_sel;
    logic [DW-1:0]   q_sel;
    logic [2*DW-1:0] packed_iq;

    always_ff @(posedge i_rx_clk or negedge i_fpga_rst_125p) begin
        if (!i_fpga_rst_125p) begin
            h_q <= '0;
            l_q <= '0;
        end else begin
            h_q <= i_dataout_h;
            l_q <= i_dataout_l;
        end
    end

    assign good_pat = h_q[DW] ^ l_q[DW];
    assign ph       = h_q[DW];
    assign is_good  = good_pat && (ph == ref_phase);

    always_ff @(posedge i_rx_clk or negedge i_fpga_rst_125p) begin
        if (!i_fpga_rst_125p) begin
            state     <= ST_IDLE;
            ref_phase <= 1'b0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
        end else begin
            state     <= state_d;
            ref_phase <= ref_phase_d;
            good_cnt  <= good_cnt_d;
            bad_cnt   <= bad_cnt_d;
        end
    end

    always_comb begin
        state_d     = state;
        ref_phase_d = ref_phase;
        good_cnt_d  = good_cnt;
        bad_cnt_d   = bad_cnt;
        wr_fire     = 1'b0;
        ovf_inc     = 1'b0;
        err_inc     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (good_pat) begin
                    ref_phase_d = ph;
                    good_cnt_d  = 8'd1;
                    state_d     = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (is_good) begin
                    // The sample that completes verification is consumed, not written.
                    if ((good_cnt + 8'd1) == LOCK_V) begin
                        good_cnt_d = '0;
                        state_d    = ST_LOCKED;
                    end else begin
                        good_cnt_d = good_cnt + 8'd1;
                    end
                end else begin
                    good_cnt_d = '0;
                    state_d    = ST_SEARCH;
                end
            end
            ST_LOCKED: begin
                if (is_good) begin
                    bad_cnt_d = '0;
                    if (i_wrfull) begin
                        ovf_inc = 1'b1;
                    end else begin
                        wr_fire = 1'b1;
                    end
                end else begin
                    err_inc = 1'b1;
                    if ((bad_cnt + 8'd1) == UNLOCK_V) begin
                        bad_cnt_d = '0;
                        state_d   = ST_SEARCH;
                    end else begin
                        bad_cnt_d = bad_cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!i_enable) begin
            state_d    = ST_IDLE;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end
    end

    assign i_sel     = ref_phase ? h_q[DW-1:0] : l_q[DW-1:0];
    assign q_sel     = ref_phase ? l_q[DW-1:0] : h_q[DW-1:0];
    assign packed_iq = PACK_Q_HIGH ? {q_sel, i_sel} : {i_sel, q_sel};

    always_ff @(posedge i_rx_clk or negedge i_fpga_rst_125p) begin
        if (!i_fpga_rst_125p) begin
            o_wr_en   <= 1'b0;
            o_wr_data <= '0;
            o_locked  <= 1'b0;
            o_phase   <= 1'b0;
        end else begin
            o_wr_en  <= wr_fire;
            o_locked <= (state_d == ST_LOCKED);
            if (wr_fire) begin
                o_wr_data <= packed_iq;
            end
            if (state_d == ST_LOCKED) begin
                o_phase <= ref_phase_d;
            end
        end
    end

    ad80305_sat_cnt #(
        .W (CNT_W)
    ) u_frame_err_cnt (
        .clk   (i_rx_clk),
        .rst_n (i_fpga_rst_125p),
        .clr   (i_clr_cnt),
        .inc   (err_inc),
        .cnt   (o_frame_err_cnt)
    );

    ad80305_sat_cnt #(
        .W (CNT_W)
    ) u_ovf_cnt (
        .clk   (i_rx_clk),
        .rst_n (i_fpga_rst_125p),
        .clr   (i_clr_cnt),
        .inc   (ovf_inc),
        .cnt   (o_ovf_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_ad80305_rx_frame_align.sv
// tb_ad80305_rx_frame_align: directed stimulus with a queue-based write scoreboard.
// Rev 1.0
`default_nettype none

module tb_ad80305_rx_frame_align;

    localparam int DW    = 12;
    localparam int CNT_W = 16;

    localparam logic [12:0] A_H  = 13'h1123;
    localparam logic [12:0] A_L  = 13'h0456;
    localparam logic [23:0] D_A  = 24'h456123;
    localparam logic [12:0] B_H  = 13'h00AB;
    localparam logic [12:0] B_L  = 13'h1F01;
    localparam logic [23:0] D_B  = 24'h0ABF01;
    localparam logic [12:0] XA_L = 13'h1456;
    localparam logic [12:0] XB_H = 13'h10AB;
    localparam logic [12:0] Z    = 13'h0000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DW:0]       dh;
    logic [DW:0]       dl;
    logic              enable;
    logic              wrfull;
    logic              clr_cnt;
    logic              wr_en;
    logic [2*DW-1:0]   wr_data;
    logic              locked;
    logic              phase;
    logic [CNT_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  ovf_cnt;

    typedef struct {
        int          cyc;
        logic [23:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [23:0] hold_model = '0;
    logic        full_q = 1'b0;
    logic        clr_q  = 1'b0;

    always #5 clk = ~clk;

    ad80305_rx_frame_align dut (
        .i_rx_clk        (clk),
        .i_fpga_rst_125p (rst_n),
        .i_dataout_h     (dh),
        .i_dataout_l     (dl),
        .i_enable        (enable),
        .i_wrfull        (wrfull),
        .i_clr_cnt       (clr_cnt),
        .o_wr_en         (wr_en),
        .o_wr_data       (wr_data),
        .o_locked        (locked),
        .o_phase         (phase),
        .o_frame_err_cnt (err_cnt),
        .o_ovf_cnt       (ovf_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Full/clear flags are given per sample; they reach the DUT one cycle later so
    // they line up with the sample when the lock logic evaluates it.
    task automatic step(input logic [12:0] h, input logic [12:0] l, input logic full,
                        input logic clr, input logic wr, input logic [23:0] d);
        exp_t e;
        @(negedge clk);
        dh      = h;
        dl      = l;
        wrfull  = full_q;
        clr_cnt = clr_q;
        full_q  = full;
        clr_q   = clr;
        if (wr) begin
            e.cyc  = cyc + 2;
            e.data = d;
            sb.push_back(e);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (!wr_en) begin
                    failures++;
                    $display("FAIL missing_write cyc=%0d actual wr_en=0 expected wr_en=1 data=0x%0h", cyc, e.data);
                end else if (wr_data !== e.data) begin
                    failures++;
                    $display("FAIL write_data cyc=%0d actual=0x%0h expected=0x%0h", cyc, wr_data, e.data);
                end
                hold_model = e.data;
            end else if (wr_en) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write cyc=%0d actual wr_en=1 data=0x%0h expected wr_en=0", cyc, wr_data);
            end else if (rst_n) begin
                chk("wr_data_hold", 32'(wr_data), 32'(hold_model));
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        dh      = '0;
        dl      = '0;
        enable  = 1'b0;
        wrfull  = 1'b0;
        clr_cnt = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en",   32'(wr_en),   0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_locked",  32'(locked),  0);
        chk("rst_phase",   32'(phase),   0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_ovf_cnt", 32'(ovf_cnt), 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (2) step(Z, Z, 0, 0, 0, '0);

        // Lock on phase 1: eight verify samples, then writes.
        repeat (8) step(A_H, A_L, 0, 0, 0, '0);
        step(A_H, A_L, 0, 0, 1, D_A);
        chk("lock1_after_7", 32'(locked), 0);
        step(A_H, A_L, 0, 0, 1, D_A);
        chk("lock1_after_8", 32'(locked), 1);
        chk("lock1_phase",   32'(phase),  1);
        repeat (4) step(A_H, A_L, 0, 0, 1, D_A);

        // Three-cycle glitch is tolerated.
        repeat (3) step(A_H, XA_L, 0, 0, 0, '0);
        repeat (2) step(A_H, A_L, 0, 0, 1, D_A);
        chk("glitch3_err",    32'(err_cnt), 3);
        chk("glitch3_locked", 32'(locked),  1);
        repeat (3) step(A_H, A_L, 0, 0, 1, D_A);

        // Four-cycle glitch drops lock; full relock needed.
        repeat (4) step(A_H, XA_L, 0, 0, 0, '0);
        repeat (2) step(A_H, A_L, 0, 0, 0, '0);
        chk("glitch4_locked", 32'(locked),  0);
        chk("glitch4_err",    32'(err_cnt), 7);
        repeat (6) step(A_H, A_L, 0, 0, 0, '0);
        step(A_H, A_L, 0, 0, 1, D_A);
        step(A_H, A_L, 0, 0, 1, D_A);
        chk("relock_a_locked", 32'(locked), 1);
        repeat (2) step(A_H, A_L, 0, 0, 1, D_A);

        // Persistent phase flip: four errors, unlock, relock on phase 0.
        repeat (6) step(B_H, B_L, 0, 0, 0, '0);
        chk("flip_locked", 32'(locked),  0);
        chk("flip_err",    32'(err_cnt), 11);
        repeat (6) step(B_H, B_L, 0, 0, 0, '0);
        step(B_H, B_L, 0, 0, 1, D_B);
        step(B_H, B_L, 0, 0, 1, D_B);
        chk("flip_relocked", 32'(locked), 1);
        chk("flip_phase",    32'(phase),  0);
        repeat (2) step(B_H, B_L, 0, 0, 1, D_B);

        // FIFO full for five samples.
        repeat (5) step(B_H, B_L, 1, 0, 0, '0);
        repeat (2) step(B_H, B_L, 0, 0, 1, D_B);
        chk("ovf_cnt_5", 32'(ovf_cnt), 5);
        repeat (2) step(B_H, B_L, 0, 0, 1, D_B);

        // Clear coinciding with an error increment wins.
        step(XB_H, B_L, 0, 1, 0, '0);
        repeat (2) step(B_H, B_L, 0, 0, 1, D_B);
        chk("clr_err",    32'(err_cnt), 0);
        chk("clr_ovf",    32'(ovf_cnt), 0);
        chk("clr_locked", 32'(locked),  1);
        step(XB_H, B_L, 0, 0, 0, '0);
        repeat (2) step(B_H, B_L, 0, 0, 1, D_B);
        chk("err_after_clr", 32'(err_cnt), 1);
        repeat (2) step(B_H, B_L, 0, 0, 1, D_B);

        // Asynchronous reset mid-stream.
        chk("wr_en_before_rst", 32'(wr_en), 1);
        #2;
        rst_n      = 1'b0;
        sb.delete();
        hold_model = '0;
        full_q     = 1'b0;
        clr_q      = 1'b0;
        wrfull     = 1'b0;
        clr_cnt    = 1'b0;
        #1;
        chk("mid_rst_wr_en",   32'(wr_en),   0);
        chk("mid_rst_wr_data", 32'(wr_data), 0);
        chk("mid_rst_locked",  32'(locked),  0);
        chk("mid_rst_phase",   32'(phase),   0);
        chk("mid_rst_err",     32'(err_cnt), 0);
        chk("mid_rst_ovf",     32'(ovf_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step(Z, Z, 0, 0, 0, '0);
        repeat (8) step(A_H, A_L, 0, 0, 0, '0);
        step(A_H, A_L, 0, 0, 1, D_A);
        chk("rst_relock_after_7", 32'(locked), 0);
        step(A_H, A_L, 0, 0, 1, D_A);
        chk("rst_relock_after_8", 32'(locked), 1);
        chk("rst_relock_phase",   32'(phase),  1);
        repeat (2) step(A_H, A_L, 0, 0, 1, D_A);
        repeat (3) step(Z, Z, 0, 0, 0, '0);
        chk("scoreboard_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
